mux2x1_arbiter: RTL
===================

# mux2x1_arbiter

Sequential two-requester arbiter that shares the 8-bit `mux2x1` datapath and a one-entry output register between two producers.
- Owns the mux `sel` line, issues per-beat grants and enforces round-robin fairness with a bounded burst length.
- Presents selected data downstream through a valid/ready handshake.
- Sits between switch/requester logic and any consumer of the muxed byte, e.g. LED or display drivers on the test top.

## Interface
Parameters:
- `WIDTH`, 8, data width of each requester and of the output.
- `HOLD_MAX`, 4, max consecutive beats one owner keeps the mux while the other requests; legal range ≥1.

Ports:
- `CLOCK_50`  in  1  system clock; all state on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0`, `req1`  in  1  requester wants to transfer; data must be held stable while `req` is high and `gnt` is low.
- `data0`, `data1`  in  WIDTH  requester payloads.
- `gnt0`, `gnt1`  out  1  beat accepted this cycle; combinational from state, `req` and output-slot status.
- `sel`  out  1  mux select; 1 means requester 1 owns the mux.
- `out_data`  out  WIDTH  registered selected byte.
- `out_valid`  out  1  `out_data` holds an unconsumed beat.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.

## Operation
- **States:** IDLE, OWN0, OWN1.
- **Registers:** `state`, `last` (last served owner), `cnt` (beats in current ownership, width `$clog2(HOLD_MAX+1)`), `out_data`, `out_valid`.
- **Derived signals:**
  - `slot_free = !out_valid | out_ready`.
  - `gntX = (state==OWNX) & reqX & slot_free`.
  - `sel = (state==OWN1)`; 0 in IDLE and OWN0.
- **IDLE transitions:**
  - both requests → OWN(!`last`);
  - only `req0` → OWN0;
  - only `req1` → OWN1;
  - none → stay.
- **OWNX transitions:**
  - `reqX` low → OWN(other) if other requests, else IDLE.
  - `gntX` with `cnt==HOLD_MAX-1` and other requesting → OWN(other).
  - Otherwise stay; `cnt` increments on each `gntX`.
  - When the other is idle, `cnt` saturates at `HOLD_MAX-1` and the owner keeps the mux indefinitely.
- **On leaving OWNX:** `last<=X`, `cnt<=0`.
- **Output register:**
  - On `gnt0|gnt1`: `out_data` <= mux output (`sel ? data1 : data0`), `out_valid<=1`.
  - Else if `out_ready`: `out_valid<=0`.
  - `out_data` holds its value when not loaded.
- **Reset values:** state IDLE, `last`=1 (requester 0 wins the first tie), `cnt`=0, `out_data`=0, `out_valid`=0; hence `gnt0`=`gnt1`=`sel`=0.
- **Reset mid-operation:** any pending output beat is discarded and ownership returns to IDLE immediately.

## Timing
- **Request to grant:** `req` rising in IDLE at cycle t → ownership at t+1 → `gnt` at t+1 if the slot is free → `out_valid` at t+2.
- **Throughput:** one beat per cycle while the owner requests and `out_ready`=1.
- **Owner switch:** no bubble. Last owner-0 beat at t, `gnt1` possible at t+1.
- **Backpressure:**
  - `out_ready`=0 with `out_valid`=1 blocks grants.
  - `out_data`/`out_valid` stay stable until accepted.
  - `cnt` does not advance while blocked.
- **Simultaneous events:** load and consume in the same cycle keeps `out_valid`=1 with the new data.
- **Owner drops `req` during backpressure:** release happens on that edge with no grant issued.

## Structure
- Package `mux_arb_pkg`: `typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;`.
- Sub-module: one `mux2x1` instance selects `data0`/`data1` under `sel`. Its output feeds the `out_data` register.
- Everything else lives in the single module: state register, counter, handshake logic.

## Test plan
- **Reset:** assert `reset` mid-burst → outputs go to 0 at once. Release, then `req0`=1, `data0`=8'hA5, `out_ready`=1 → `gnt0` 1 cycle after `req0`, `out_data`=A5 with `out_valid` one cycle later.
- **Tie at start:** `req0`=`req1`=1 from IDLE after reset → OWN0 first. With `HOLD_MAX`=4: four `gnt0` beats, then `sel`=1 and four `gnt1` beats, alternating, no idle cycle.
- **Backpressure:** `out_ready`=0 for 3 cycles while owner 1 requests with `data1`=8'h3C → `out_valid` held, no `gnt1`, `cnt` frozen. `out_ready`=1 → 3C consumed and the next beat granted the same cycle.
- **Early release:** `req0` drops after 2 beats while `req1`=1 → OWN1 on the next edge, `last`=0. A later tie grants requester 1.
- **Single requester:** only `req1` high for 10 cycles → 10 consecutive `gnt1` beats. Ownership never leaves OWN1 despite `HOLD_MAX`.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types for the two-requester mux arbiter.
// Ownership states of the arbiter FSM.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } arb_state_t;

endpackage

// File: rtl/mux2x1.sv
// Plain 2:1 byte-wide multiplexer used as the arbiter's shared datapath.
// sel=1 routes in1 to the output.
module mux2x1 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? in1 : in0;

endmodule

// File: rtl/mux2x1_arbiter.sv
// Round-robin arbiter sharing one mux2x1 and a one-entry output register between two
// producers, with a bounded burst length and a valid/ready output handshake.
module mux2x1_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned      CNT_W   = $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX - 1);

    arb_state_t       state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] mux_out;
    logic             slot_free;

    mux2x1 #(
        .WIDTH(WIDTH)
    ) u_mux (
        .in0(data0),
        .in1(data1),
        .sel(sel),
        .y  (mux_out)
    );

    // The output slot can take a new beat if empty or being drained this cycle.
    assign slot_free = !out_valid_q | out_ready;
    assign gnt0      = (state_q == OWN0) & req0 & slot_free;
    assign gnt1      = (state_q == OWN1) & req1 & slot_free;
    assign sel       = (state_q == OWN1);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    state_d = last_q ? OWN0 : OWN1;
                end else if (req0) begin
                    state_d = OWN0;
                end else if (req1) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!req0) begin
                    state_d = req1 ? OWN1 : IDLE;
                    last_d  = 1'b0;
                    cnt_d   = '0;
                end else if (gnt0) begin
                    // At the burst limit cnt saturates until the other side asks.
                    if (cnt_q == CNT_MAX) begin
                        if (req1) begin
                            state_d = OWN1;
                            last_d  = 1'b0;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            OWN1: begin
                if (!req1) begin
                    state_d = req0 ? OWN0 : IDLE;
                    last_d  = 1'b1;
                    cnt_d   = '0;
                end else if (gnt1) begin
                    if (cnt_q == CNT_MAX) begin
                        if (req0) begin
                            state_d = OWN0;
                            last_d  = 1'b1;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // A load wins over a drain, so load+consume in one cycle keeps out_valid high.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (gnt0 || gnt1) begin
            out_data_q  <= mux_out;
            out_valid_q <= 1'b1;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule
